// File: rtl/iq_pkg.sv
// Shared definitions for the I/Q loopback receive path: sample layout,
// the six-symbol phase sequence with its successor rule, and FSM states.
package iq_pkg;

  localparam int SAMPLE_W = 4;

  // Bit positions inside a packed sample {q1,q0,i1,i0}
  localparam int I0_POS = 0;
  localparam int I1_POS = 1;
  localparam int Q0_POS = 2;
  localparam int Q1_POS = 3;

  // Legal phase cycle: SYM0 -> SYM1 -> ... -> SYM5 -> SYM0
  localparam logic [SAMPLE_W-1:0] SYM0 = 4'h4;
  localparam logic [SAMPLE_W-1:0] SYM1 = 4'h9;
  localparam logic [SAMPLE_W-1:0] SYM2 = 4'hE;
  localparam logic [SAMPLE_W-1:0] SYM3 = 4'hB;
  localparam logic [SAMPLE_W-1:0] SYM4 = 4'h6;
  localparam logic [SAMPLE_W-1:0] SYM5 = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } iq_state_e;

  function automatic logic is_symbol(input logic [SAMPLE_W-1:0] s);
    return (s == SYM0) || (s == SYM1) || (s == SYM2) ||
           (s == SYM3) || (s == SYM4) || (s == SYM5);
  endfunction

  // Next legal symbol; a non-symbol maps to itself so it never matches a change.
  function automatic logic [SAMPLE_W-1:0] successor(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] n;
    case (s)
      SYM0:    n = SYM1;
      SYM1:    n = SYM2;
      SYM2:    n = SYM3;
      SYM3:    n = SYM4;
      SYM4:    n = SYM5;
      SYM5:    n = SYM0;
      default: n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/iq_seq_checker.sv
// Watches a synchronized I/Q sample stream and counts changes that do not
// follow the six-symbol phase sequence. Holding a value is always legal.
module iq_seq_checker
  import iq_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                err_clr,
  output logic [ERR_W-1:0]    err_cnt
);

  logic [SAMPLE_W-1:0] prev;
  logic                violation;

  // A change is legal only when the old value is a symbol and the new one is its successor
  always_comb begin
    violation = (sample != prev) && !(is_symbol(prev) && (successor(prev) == sample));
  end

  // Track previous sample and keep a saturating error count; clear beats increment
  always_ff @(posedge clock) begin
    if (reset) begin
      prev    <= '0;
      err_cnt <= '0;
    end else begin
      prev <= sample;
      if (err_clr) begin
        err_cnt <= '0;
      end else if (violation && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: rtl/iq_capture_rx.sv
// Loopback receiver for the 2-bit I/Q generator: synchronizes the four pins,
// checks the phase sequence, captures a 2**ADDR_W sample window on trigger and
// streams it out.
//
// Output handshake: a sample moves when rd_valid && rd_ready at a rising edge.
// Once rd_valid is high, rd_data/rd_last stay stable until that transfer, and
// rd_valid never drops without a transfer. rd_last marks address DEPTH-1.
module iq_capture_rx
  import iq_pkg::*;
#(
  parameter int                  ADDR_W     = 13,
  parameter logic [SAMPLE_W-1:0] TRIG_VALUE = 4'h4,
  parameter int                  ERR_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in0i,
  input  logic                in1i,
  input  logic                in0q,
  input  logic                in1q,
  input  logic                arm,
  input  logic                force_trig,
  input  logic                err_clr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic                busy,
  output logic [ERR_W-1:0]    err_cnt,
  output iq_state_e           dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [SAMPLE_W-1:0] s_pins;
  logic [SAMPLE_W-1:0] s_meta;
  logic [SAMPLE_W-1:0] s_sync;

  iq_state_e           state;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   raddr;
  logic                rd_issued_all;
  logic                pend;
  logic                pend_last;
  logic                sk_valid;
  logic                sk_last;
  logic [SAMPLE_W-1:0] sk_data;
  logic [SAMPLE_W-1:0] ram_q;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic                trig_hit;
  logic                we;
  logic                fire;
  logic                issue;
  logic [1:0]          occ;

  // Pack the asynchronous pins into one sample
  always_comb begin
    s_pins         = '0;
    s_pins[I0_POS] = in0i;
    s_pins[I1_POS] = in1i;
    s_pins[Q0_POS] = in0q;
    s_pins[Q1_POS] = in1q;
  end

  // Two-flop synchronizer for the whole sample
  always_ff @(posedge clock) begin
    if (reset) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= s_pins;
      s_sync <= s_meta;
    end
  end

  iq_seq_checker #(.ERR_W(ERR_W)) u_seq_checker (
    .clock   (clock),
    .reset   (reset),
    .sample  (s_sync),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
  );

  // Read issue keeps output + skid + in-flight read at most two, so a returning
  // RAM word always has a register to land in.
  always_comb begin
    trig_hit = (s_sync == TRIG_VALUE) || force_trig;
    we       = ((state == ST_ARMED) && trig_hit) || (state == ST_CAPTURE);
    fire     = rd_valid && rd_ready;
    occ      = {1'b0, rd_valid} + {1'b0, sk_valid} + {1'b0, pend};
    issue    = (state == ST_DRAIN) && !rd_issued_all && ((occ - {1'b0, fire}) < 2'd2);
  end

  // Capture RAM: written during capture, read one word per issue during drain
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= s_sync;
    end
    if (issue) begin
      ram_q <= mem[raddr];
    end
  end

  // Capture/drain control with registered handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      waddr         <= '0;
      raddr         <= '0;
      rd_issued_all <= 1'b0;
      pend          <= 1'b0;
      pend_last     <= 1'b0;
      sk_valid      <= 1'b0;
      sk_last       <= 1'b0;
      sk_data       <= '0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      rd_data       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
            waddr <= '0;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            state <= ST_CAPTURE;
            waddr <= waddr + ADDR_W'(1);
          end
        end
        ST_CAPTURE: begin
          waddr <= waddr + ADDR_W'(1);
          if (waddr == '1) begin
            state         <= ST_DRAIN;
            raddr         <= '0;
            rd_issued_all <= 1'b0;
          end
        end
        ST_DRAIN: begin
          pend <= issue;
          if (issue) begin
            raddr     <= raddr + ADDR_W'(1);
            pend_last <= (raddr == '1);
            if (raddr == '1) begin
              rd_issued_all <= 1'b1;
            end
          end
          if (fire || !rd_valid) begin
            if (sk_valid) begin
              rd_valid <= 1'b1;
              rd_data  <= sk_data;
              rd_last  <= sk_last;
              sk_valid <= pend;
              sk_data  <= ram_q;
              sk_last  <= pend_last;
            end else if (pend) begin
              rd_valid <= 1'b1;
              rd_data  <= ram_q;
              rd_last  <= pend_last;
            end else begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
          end else if (pend) begin
            sk_valid <= 1'b1;
            sk_data  <= ram_q;
            sk_last  <= pend_last;
          end
          if (fire && rd_last) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            sk_valid <= 1'b0;
            pend     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_iq_capture_rx.sv
// Bench for iq_capture_rx: a behavioural model (pin delay line, sequence rule,
// window capture into an expected queue) against the DUT, one task per scenario.
module tb_iq_capture_rx;
  import iq_pkg::*;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int ERR_W  = 16;
  localparam logic [3:0] TRIG = 4'h4;

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] pins = 4'h0;
  logic in0i, in1i, in0q, in1q;
  logic arm = 1'b0, force_trig = 1'b0, err_clr = 1'b0, rd_ready = 1'b0;
  logic [3:0] rd_data;
  logic rd_valid, rd_last, busy;
  logic [ERR_W-1:0] err_cnt;
  iq_state_e dbg_state;

  assign {in1q, in0q, in1i, in0i} = pins;

  always #5 clock = ~clock;

  iq_capture_rx #(.ADDR_W(ADDR_W), .TRIG_VALUE(TRIG), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset(reset),
    .in0i(in0i), .in1i(in1i), .in0q(in0q), .in1q(in1q),
    .arm(arm), .force_trig(force_trig), .err_clr(err_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [3:0] seq_tab [6] = '{4'h4, 4'h9, 4'hE, 4'hB, 4'h6, 4'h1};
  logic [3:0] sq [$];            // sq[0] = synchronized value, sq[1] = first-flop value
  logic [3:0] exp_q [$];         // captured window, oldest first
  logic [3:0] m_prev;
  logic [ERR_W-1:0] m_err;
  bit m_armed, m_drain;
  int m_cap, m_xfers;

  function automatic bit legal_step(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 6; i++) if (seq_tab[i] == a) return seq_tab[(i + 1) % 6] == b;
    return 1'b0;
  endfunction

  function automatic iq_state_e exp_state();
    if (m_armed) return ST_ARMED;
    if (m_cap > 0) return ST_CAPTURE;
    if (m_drain) return ST_DRAIN;
    return ST_IDLE;
  endfunction

  always @(posedge clock) begin
    logic [3:0] cur;
    bit was_idle;
    if (reset) begin
      sq = '{4'h0, 4'h0};
      m_prev = 4'h0; m_err = '0;
      m_armed = 0; m_drain = 0; m_cap = 0; m_xfers = 0;
      exp_q.delete();
    end else begin
      cur = sq[0];
      was_idle = !m_armed && (m_cap == 0) && !m_drain;
      if (err_clr) m_err = '0;
      else if (cur != m_prev && !legal_step(m_prev, cur) && m_err != '1) m_err = m_err + 1'b1;
      m_prev = cur;
      if (m_drain && rd_valid && rd_ready) begin
        m_xfers++;
        if (m_xfers == DEPTH) begin m_drain = 0; m_xfers = 0; end
      end
      if (m_cap > 0) begin
        exp_q.push_back(cur);
        m_cap--;
        if (m_cap == 0) m_drain = 1;
      end else if (m_armed && (cur == TRIG || force_trig)) begin
        exp_q.push_back(cur);
        m_cap = DEPTH - 1;
        m_armed = 0;
      end else if (arm && was_idle) begin
        m_armed = 1;
      end
      void'(sq.pop_front());
      sq.push_back(pins);
    end
  end

  // ---------------- background pin drivers ----------------
  bit seq_on = 0, rnd_on = 0;
  int seq_idx = 0, seq_cnt = 0;

  always @(negedge clock) begin
    if (seq_on) begin
      if (seq_cnt == 9) begin seq_cnt = 0; seq_idx = (seq_idx + 1) % 6; end
      else seq_cnt++;
      pins = seq_tab[seq_idx];
    end else if (rnd_on) begin
      pins = 4'($urandom_range(0, 15));
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // ---------------- drain and check against expected queue ----------------
  task automatic drain_and_check(input bit random_ready, input bit poke_arm,
                                 output logic [3:0] first_d, output logic [3:0] last_d);
    int idx, cyc, wait_c;
    bit stalled, poked, poke_chk;
    logic [3:0] held_d, e;
    logic held_l;
    idx = 0; stalled = 0; poked = 0; poke_chk = 0;
    first_d = 'x; last_d = 'x; held_d = '0; held_l = 0;
    cyc = 0;
    while (!m_drain && cyc < DEPTH + 100) begin @(negedge clock); cyc++; end
    n_cmp++;
    if (!m_drain) begin
      n_bad++;
      $display("FAIL drain_start: capture did not complete within %0d cycles", cyc);
      return;
    end
    wait_c = 0;
    while (!rd_valid && wait_c < 10) begin @(negedge clock); wait_c++; end
    n_cmp++;
    if (wait_c > 2) begin
      n_bad++;
      $display("FAIL first_valid_latency: got %0d cycles, want <= 2", wait_c);
    end
    cyc = 0;
    while (idx < DEPTH && cyc < 4 * DEPTH + 100) begin
      rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_chk) begin
        n_cmp++;
        if (dbg_state !== ST_DRAIN) begin
          n_bad++;
          $display("FAIL arm_in_drain: state %0d want %0d", dbg_state, ST_DRAIN);
        end
        poke_chk = 0;
      end
      if (stalled) begin
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== held_d || rd_last !== held_l) begin
          n_bad++;
          $display("FAIL stall_hold[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   idx, rd_valid, rd_data, rd_last, held_d, held_l);
        end
      end
      stalled = 0;
      if (poke_arm && !poked && idx >= DEPTH / 2) begin
        arm = 1'b1; poked = 1; poke_chk = 1;
      end else begin
        arm = 1'b0;
      end
      if (rd_valid) begin
        if (rd_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
          n_cmp++;
          if (rd_data !== e || rd_last !== (idx == DEPTH - 1)) begin
            n_bad++;
            $display("FAIL drain_data[%0d]: got d=%h l=%b want d=%h l=%b",
                     idx, rd_data, rd_last, e, (idx == DEPTH - 1));
          end
          if (idx == 0) first_d = rd_data;
          last_d = rd_data;
          idx++;
        end else begin
          stalled = 1; held_d = rd_data; held_l = rd_last;
        end
      end
      @(negedge clock);
      cyc++;
    end
    arm = 1'b0;
    rd_ready = 1'b0;
    n_cmp++;
    if (idx != DEPTH) begin
      n_bad++;
      $display("FAIL drain_count: got %0d samples want %0d", idx, DEPTH);
    end
    n_cmp++;
    if (rd_valid !== 1'b0 || dbg_state !== ST_IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_end: got v=%b state=%0d busy=%b want v=0 state=%0d busy=0",
               rd_valid, dbg_state, busy, ST_IDLE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    pins = 4'($urandom_range(0, 15));
    cycles(3);
    n_cmp++;
    if (busy !== 0 || rd_valid !== 0 || rd_last !== 0 || err_cnt !== '0 || dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b v=%b l=%b err=%0d state=%0d want 0/0/0/0/%0d",
               busy, rd_valid, rd_last, err_cnt, dbg_state, ST_IDLE);
    end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_seq_violation();
    logic [3:0] steps [4];
    steps = '{4'hE, 4'h7, 4'h1, 4'h4};
    pins = 4'h4; cycles(4);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0; cycles(2);
    foreach (steps[i]) begin pins = steps[i]; cycles(3); end
    cycles(4);
    n_cmp++;
    if (err_cnt !== 16'd3 || m_err !== 16'd3) begin
      n_bad++;
      $display("FAIL seq_violation_count: got %0d (model %0d) want 3", err_cnt, m_err);
    end
    pins = 4'h7;                 // 4 -> 7 is a violation
    cycles(2);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    n_cmp++;
    if (err_cnt !== '0) begin
      n_bad++;
      $display("FAIL clr_wins: got %0d want 0", err_cnt);
    end
    pins = 4'hE;                 // 7 -> E, counted normally
    cycles(4);
    n_cmp++;
    if (err_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL after_clr_count: got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_random_err();
    int r;
    bit found;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      n_cmp++;
      if (err_cnt !== m_err) begin
        n_bad++;
        $display("FAIL random_err[%0d]: got %0d want %0d", k, err_cnt, m_err);
      end
      err_clr = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 7);
      if (r >= 4 && r <= 6) begin
        found = 0;
        for (int i = 0; i < 6; i++)
          if (!found && seq_tab[i] == pins) begin pins = seq_tab[(i + 1) % 6]; found = 1; end
        if (!found) pins = seq_tab[0];
      end else if (r == 7) begin
        pins = 4'($urandom_range(0, 15));
      end
    end
    err_clr = 1'b0;
    cycles(1);
  endtask

  task automatic test_reset_mid_capture();
    pins = 4'h4; cycles(3);
    arm = 1'b1; cycles(1); arm = 1'b0;
    cycles(100);
    n_cmp++;
    if (dbg_state !== exp_state() || dbg_state !== ST_CAPTURE) begin
      n_bad++;
      $display("FAIL mid_capture_state: got %0d want %0d", dbg_state, ST_CAPTURE);
    end
    reset = 1'b1; cycles(1); reset = 1'b0;
    n_cmp++;
    if (busy !== 0 || rd_valid !== 0 || err_cnt !== '0 || dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_mid_capture: busy=%b v=%b err=%0d state=%0d want 0/0/0/%0d",
               busy, rd_valid, err_cnt, dbg_state, ST_IDLE);
    end
    cycles(3);
  endtask

  task automatic test_clean_sequence();
    logic [3:0] first_d, last_d;
    pins = 4'h1; cycles(4);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    seq_idx = 5; seq_cnt = 0; seq_on = 1;
    cycles(2);
    arm = 1'b1; cycles(1); arm = 1'b0;
    n_cmp++;
    if (dbg_state !== exp_state() || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_armed: state=%0d busy=%b want %0d/1", dbg_state, busy, exp_state());
    end
    drain_and_check(1'b0, 1'b0, first_d, last_d);
    seq_on = 0;
    n_cmp++;
    if (first_d !== 4'h4) begin
      n_bad++;
      $display("FAIL clean_first: got %h want 4", first_d);
    end
    n_cmp++;
    if (err_cnt !== '0 || m_err !== '0) begin
      n_bad++;
      $display("FAIL clean_err: got %0d (model %0d) want 0", err_cnt, m_err);
    end
  endtask

  task automatic test_force_trig();
    logic [3:0] first_d, last_d;
    pins = 4'hB; cycles(4);
    arm = 1'b1; cycles(1); arm = 1'b0;
    cycles(3);
    n_cmp++;
    if (dbg_state !== ST_ARMED) begin
      n_bad++;
      $display("FAIL force_wait_armed: got %0d want %0d", dbg_state, ST_ARMED);
    end
    force_trig = 1'b1; cycles(1); force_trig = 1'b0;
    drain_and_check(1'b0, 1'b0, first_d, last_d);
    n_cmp++;
    if (first_d !== 4'hB || last_d !== 4'hB) begin
      n_bad++;
      $display("FAIL force_samples: got first=%h last=%h want B/B", first_d, last_d);
    end
  endtask

  task automatic test_backpressure_arm_ignored();
    logic [3:0] first_d, last_d;
    rnd_on = 1; cycles(3);
    arm = 1'b1; cycles(1); arm = 1'b0;
    cycles(2);
    force_trig = 1'b1; cycles(1); force_trig = 1'b0;
    cycles(50);
    arm = 1'b1; cycles(1); arm = 1'b0;
    n_cmp++;
    if (dbg_state !== ST_CAPTURE || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL arm_in_capture: state=%0d busy=%b want %0d/1", dbg_state, busy, ST_CAPTURE);
    end
    drain_and_check(1'b1, 1'b1, first_d, last_d);
    rnd_on = 0;
    cycles(3);
    n_cmp++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_drain: state=%0d busy=%b want %0d/0", dbg_state, busy, ST_IDLE);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_seq_violation();
    test_random_err();
    test_reset_mid_capture();
    test_clean_sequence();
    test_force_trig();
    test_backpressure_arm_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_capture_rx.md
Name: iq_capture_rx

Overview:
Receive-side counterpart of the 2-bit I/Q waveform generator. It samples the four 1-bit I/Q lines through a 2-flop synchronizer and checks them against the 6-symbol phase sequence. On a trigger it records a fixed-length window into on-chip RAM, then streams the window out over a valid/ready interface. It is used for loopback verification of the DAC path on the same board.

Parameters:
ADDR_W, 13, log2 of capture depth (DEPTH = 2**ADDR_W = 8192 samples)
TRIG_VALUE, 4'h4, packed sample that starts capture (I=0, Q=1, the first sequence symbol)
ERR_W, 16, width of the sequence-error counter

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
in0i  in  1  I bit 0 (asynchronous to clock)
in1i  in  1  I bit 1 (asynchronous)
in0q  in  1  Q bit 0 (asynchronous)
in1q  in  1  Q bit 1 (asynchronous)
arm  in  1  single-cycle request to arm the trigger
force_trig  in  1  start capture immediately while armed
err_clr  in  1  clears err_cnt
rd_data  out  4  captured sample {q1,q0,i1,i0}
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
rd_last  out  1  marks sample DEPTH-1; qualified by rd_valid
busy  out  1  high in ARMED, CAPTURE or DRAIN
err_cnt  out  ERR_W  count of sequence violations, saturating

Behaviour:
- Packing: s = {in1q,in0q,in1i,in0i}. Each line passes through 2 flops; s_sync is valid 2 cycles after the pins. All decisions use s_sync.
- Sequence checker (always active): the legal cycle is 4'h4 -> 4'h9 -> 4'hE -> 4'hB -> 4'h6 -> 4'h1 -> 4'h4.
  - When s_sync differs from its previous-cycle value, err_cnt increments unless the new value is the successor of the old one.
  - A change to any value outside the set counts as an error.
  - Holding the same value is never an error.
  - err_cnt saturates at all-ones.
  - err_clr zeroes err_cnt. If err_clr and an error occur in the same cycle, err_clr wins and the result is 0.
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
  - IDLE -> ARMED on arm. arm in any other state is ignored.
  - ARMED -> CAPTURE when s_sync == TRIG_VALUE or force_trig. The triggering cycle's s_sync is written to address 0.
  - CAPTURE: one sample is written per cycle with the write address incrementing. After address DEPTH-1 is written, go to DRAIN. Exactly DEPTH samples are written.
  - DRAIN: stream addresses 0..DEPTH-1 in order.
    - The first rd_valid is asserted no later than 2 cycles after entering DRAIN.
    - A transfer occurs when rd_valid and rd_ready are both high.
    - While rd_valid is high and rd_ready is low, rd_data and rd_last hold stable.
    - rd_last is high only with address DEPTH-1.
    - After the rd_last transfer, the next state is IDLE and rd_valid is low the following cycle.
  - Back-to-back transfers sustain 1 sample/cycle when rd_ready is held high. The implementation uses a prefetch/skid register to absorb the 1-cycle RAM read latency.
- Reset (any state, including mid-CAPTURE/DRAIN):
  - state IDLE, rd_valid 0, rd_last 0, busy 0, err_cnt 0.
  - Synchronizer flops and previous-sample register are cleared to 0.
  - RAM contents are not cleared and are undefined for the next capture until overwritten.
- Address counters wrap naturally at ADDR_W bits. No partial captures.

Decomposition:
- Shared package iq_pkg holds:
  - sample width constant (4) and field positions;
  - the six sequence symbol constants and a successor function;
  - the FSM state enum.
- Natural sub-module: iq_seq_checker (synchronized sample in, err_cnt out, err_clr), reusable on other loopback paths.
- The RAM is inferred inside iq_capture_rx as a simple dual-port (write in CAPTURE, read in DRAIN).

Test Plan:
1. Reset mid-CAPTURE: arm, trigger, then after 100 samples pulse reset -> busy=0, rd_valid=0, err_cnt=0, next cycle state IDLE.
2. Clean sequence: drive 4'h4,9,E,B,6,1 repeating, each held 10 cycles; pulse arm -> capture begins on the first synced 4'h4. Drain with rd_ready=1 -> 8192 samples, first is 4'h4, rd_last on the 8192nd only, err_cnt stays 0.
3. Sequence violation: drive 4'h4 -> 4'hE -> 4'h7 -> 4'h1 -> 4'h4 -> err_cnt=3. Pulse err_clr in the same cycle as a further violation -> err_cnt=0.
4. force_trig: hold s constant at 4'hB, arm, pulse force_trig -> all 8192 captured samples are 4'hB.
5. Backpressure: during DRAIN toggle rd_ready randomly (50%) -> no sample lost or duplicated, rd_data stable while stalled, addresses strictly 0..8191.
6. arm ignored: pulse arm during CAPTURE and during DRAIN -> no state change. After drain completes, state is IDLE, not ARMED.
